// File: rtl/edge_event_logger.sv
// edge_event_logger
//   Watches two 2-bit buses and logs every cycle where {a,b} differs from the
//   previous cycle's value. Each logged event is {timestamp, a, b}. Events go
//   into a DEPTH-entry FIFO that a consumer drains with a valid/ready handshake.
//
// Parameters
//   DEPTH : FIFO entries (power of two, 2..64)
//   TS_W  : timestamp width; the counter wraps silently
//
// Ports
//   clk       : rising-edge clock for all state
//   rst_n     : asynchronous active-low reset
//   a, b      : observed buses, synchronous to clk
//   clr       : synchronous flush (empties FIFO, clears overflow, zeroes ts)
//   out_valid : head event available (level != 0)
//   out_ready : consumer accepts head event
//   out_data  : head event {ts, a, b}
//   level     : FIFO occupancy
//   overflow  : sticky, an event was dropped because the FIFO was full
//   drop_cnt  : saturating count of dropped events (EDGE_LOG_DROP_CNT_EN only)
//
// Build option
//   EDGE_LOG_DROP_CNT_EN : when defined, adds the drop_cnt output and counter.

module edge_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               a,
  input  logic [1:0]               b,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W+3:0]          out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef EDGE_LOG_DROP_CNT_EN
  ,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [TS_W-1:0] ts_q;
  logic [3:0]      prev_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [TS_W+3:0] mem_q [DEPTH];

  logic [3:0] cur;
  logic       evt;
  logic       full;
  logic       empty;
  logic       pop;
  logic       push;
  logic       drop;

  assign cur   = {a, b};
  assign evt   = (cur != prev_q);
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);
  // clr wins over both push and pop.
  assign pop   = !empty && out_ready && !clr;
  // A same-edge pop frees a slot, so a full FIFO can still accept the event.
  assign push  = evt && !clr && (!full || pop);
  assign drop  = evt && !clr && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q       <= '0;
      prev_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q       <= clr ? '0 : ts_q + TS_W'(1);
      prev_q     <= cur;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: an entry is only visible once level counts it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_q, cur};
  end

`ifdef EDGE_LOG_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (clr) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid = !empty;
  // Forced to zero when empty so the output reads 0 under reset.
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_logger.sv
// Testbench for edge_event_logger: a main instance (DEPTH=8, TS_W=16) driven
// cycle by cycle with an expected-event queue, plus a TS_W=4 instance sharing
// the same stimulus for the timestamp wrap case.

module tb_edge_event_logger;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  a, b;
  logic        clr;
  logic        out_ready, out_ready4;
  logic        out_valid, out_valid4;
  logic [19:0] out_data;
  logic [7:0]  out_data4;
  logic [3:0]  level, level4;
  logic        overflow, overflow4;
`ifdef EDGE_LOG_DROP_CNT_EN
  logic [7:0]  drop_cnt, drop_cnt4;
`endif

  always #5 clk = ~clk;

  edge_event_logger #(.DEPTH(8), .TS_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow)
`ifdef EDGE_LOG_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  edge_event_logger #(.DEPTH(8), .TS_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .level(level4), .overflow(overflow4)
`ifdef EDGE_LOG_DROP_CNT_EN
    , .drop_cnt(drop_cnt4)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  logic [15:0] ts_m;
  logic [3:0]  prev_m;
  logic        ovf_m;
  int          drops_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ts_m    = '0;
    prev_m  = '0;
    ovf_m   = 1'b0;
    drops_m = 0;
  endtask

  // Drive one cycle of stimulus, update the expected state for that edge,
  // then compare the main instance after the edge.
  task automatic cycle(input logic [3:0] ab, input logic rdy, input logic c);
    logic pop;
    {a, b}    = ab;
    out_ready = rdy;
    clr       = c;
    pop = (exp_q.size() != 0) && rdy;
    if (c) begin
      exp_q.delete();
      ovf_m   = 1'b0;
      drops_m = 0;
      ts_m    = '0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (ab != prev_m) begin
        if (exp_q.size() < 8) exp_q.push_back({ts_m, ab});
        else begin
          ovf_m = 1'b1;
          if (drops_m < 255) drops_m++;
        end
      end
      ts_m = ts_m + 16'd1;
    end
    prev_m = ab;
    @(posedge clk);
    #1;
    check("level", level, exp_q.size());
    check("out_valid", out_valid, exp_q.size() != 0);
    check("out_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 20'd0);
    check("overflow", overflow, ovf_m);
`ifdef EDGE_LOG_DROP_CNT_EN
    check("drop_cnt", drop_cnt, drops_m);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    a          = 2'b01;
    b          = 2'b00;
    clr        = 1'b0;
    out_ready  = 1'b0;
    out_ready4 = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_level4", level4, 0);
    rst_n = 1'b1;

    // First edge after release logs a=01,b=00 at ts=0
    cycle(4'b0100, 1'b0, 1'b0);
    check("release_data", out_data, {16'd0, 4'b0100});
    check("release_level", level, 1);

    // Hold, then change: second event at ts=6
    repeat (5) cycle(4'b0100, 1'b0, 1'b0);
    check("hold_level", level, 1);
    cycle(4'b1000, 1'b0, 1'b0);
    check("second_level", level, 2);

    // Seven more changes: nine in all, one dropped
    for (int i = 0; i < 7; i++) cycle(4'(i + 3), 1'b0, 1'b0);
    check("full_level", level, 8);
    check("full_overflow", overflow, 1);
    check("full_head", out_data, {16'd0, 4'b0100});
`ifdef EDGE_LOG_DROP_CNT_EN
    check("full_drop_cnt", drop_cnt, 1);
`endif

    // Read out in order; after the first pop the head is the ts=6 event
    cycle(4'd9, 1'b1, 1'b0);
    check("second_event", out_data, {16'd6, 4'b1000});
    repeat (6) cycle(4'd9, 1'b1, 1'b0);
    check("drain_level", level, 1);

    // clr with a change and out_ready: everything flushed, nothing logged
    cycle(4'b0110, 1'b1, 1'b1);
    check("clr_level", level, 0);
    check("clr_overflow", overflow, 0);
    check("clr_valid", out_valid, 0);
    cycle(4'b0110, 1'b0, 1'b0);
    cycle(4'b0101, 1'b0, 1'b0);
    check("post_clr_ts", out_data, {16'd1, 4'b0101});

    // Fill to 8, then a change with a same-edge pop must not drop
    for (int i = 0; i < 7; i++) cycle(4'(i + 8), 1'b0, 1'b0);
    check("refill_level", level, 8);
    cycle(4'd3, 1'b1, 1'b0);
    check("full_pop_push_level", level, 8);
    check("full_pop_push_overflow", overflow, 0);
    repeat (8) cycle(4'd3, 1'b1, 1'b0);
    check("empty_again", level, 0);
    cycle(4'd3, 1'b1, 1'b0);

    // Timestamp wrap on the 4-bit instance
    cycle(4'd3, 1'b0, 1'b1);
    check("wrap_clr_level4", level4, 0);
    while (ts_m != 16'd15) cycle(4'd3, 1'b0, 1'b0);
    cycle(4'b1100, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    check("wrap_level4", level4, 2);
    check("wrap_first", out_data4, {4'd15, 4'b1100});
    out_ready4 = 1'b1;
    cycle(4'b0011, 1'b0, 1'b0);
    out_ready4 = 1'b0;
    check("wrap_second", out_data4, {4'd0, 4'b0011});

    // Reset in the middle of operation discards buffered events
    rst_n = 1'b0;
    #1;
    check("midrst_level", level, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_data", out_data, 0);
    check("midrst_level4", level4, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b0011, 1'b1, 1'b0);
    check("midrst_event", out_data, {16'd0, 4'b0011});
    cycle(4'b0011, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
